// File: rtl/top_level_shift_reg_pkg.sv
// top_level_shift_reg_pkg: shared limits and sizing helper for the bit-delay line
package top_level_shift_reg_pkg;
  localparam int MIN_LENGTH = 1;
  localparam int MAX_LENGTH = 1024;
  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/top_level_shift_reg_shift_stage.sv
// shift_stage: single D flop with synchronous active-low clear
module shift_stage (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge i_clk) o_q <= !i_rst ? 1'b0 : i_d;
endmodule

// File: rtl/top_level_shift_reg.sv
// top_level_shift_reg: LENGTH-cycle serial bit-delay line with parallel tap and fill flag
module top_level_shift_reg
  import top_level_shift_reg_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_din,
  output logic              o_dout,
  output logic [LENGTH-1:0] o_q,
  output logic              o_full
);
  localparam int CW = count_width(LENGTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(LENGTH);
  if (LENGTH < MIN_LENGTH || LENGTH > MAX_LENGTH) begin : g_bad_length
    $error("top_level_shift_reg: LENGTH %0d out of range", LENGTH);
  end
  logic [LENGTH:0] d_chain;
  logic [CW-1:0]   count;
  assign d_chain = {o_q, i_din};
  for (genvar k = 0; k < LENGTH; k++) begin : g_stage
    shift_stage u_stage (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (d_chain[k]),
      .o_q   (o_q[k])
    );
  end
  always_ff @(posedge i_clk)
    count <= !i_rst ? '0 : (count == FULL_COUNT ? count : count + 1'b1);
  assign o_dout = o_q[LENGTH-1];
  assign o_full = count == FULL_COUNT;
endmodule

// File: tb/tb_top_level_shift_reg.sv
// tb_top_level_shift_reg: directed and random checks of the delay line against a history-queue model
module tb_top_level_shift_reg;
  localparam int L = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout, full, dout1, full1;
  logic [L-1:0] q;
  logic [0:0] q1;
  int checks = 0;
  int errors = 0;
  bit hist[$];
  int n = 0;
  logic [L-1:0] e;
  logic [L-1:0] e1;
  always #5 clk = ~clk;
  top_level_shift_reg #(.LENGTH(L)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_din (din),
    .o_dout(dout),
    .o_q   (q),
    .o_full(full)
  );
  top_level_shift_reg #(.LENGTH(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .i_din (din),
    .o_dout(dout1),
    .o_q   (q1),
    .o_full(full1)
  );
  task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [L-1:0] exp_q(input int len);
    logic [L-1:0] r = '0;
    for (int k = 0; k < len; k++) if (k < hist.size()) r[k] = hist[k];
    return r;
  endfunction
  task automatic step(input bit r, input bit d);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    if (!r) begin
      hist.delete();
      n = 0;
    end else begin
      hist.push_front(d);
      if (hist.size() > L) void'(hist.pop_back());
      n++;
    end
    #1;
    e = exp_q(L);
    e1 = exp_q(1);
    check("o_q", q, e);
    check("o_dout", L'(dout), L'(e[L-1]));
    check("o_full", L'(full), L'(n >= L));
    check("l1_o_q", L'(q1), L'(e1[0]));
    check("l1_o_dout", L'(dout1), L'(e1[0]));
    check("l1_o_full", L'(full1), L'(n >= 1));
  endtask
  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("reset_q", q, '0);
    check("reset_full", L'(full), '0);
    for (int i = 0; i < L; i++) begin
      step(1'b1, i == 0);
      check("pulse_walk", q, L'(1) << i);
    end
    check("pulse_dout", L'(dout), L'(1));
    for (int i = 0; i < L; i++) step(1'b1, (8'hA5 >> i) & 1);
    check("word_q", q, 8'hA5);
    check("word_full", L'(full), L'(1));
    for (int i = 0; i < L; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("mid_q", q, 8'h0F);
    step(1'b0, 1'b1);
    check("midrst_q", q, '0);
    check("midrst_full", L'(full), '0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom));
      check("sat_full", L'(full), L'(i >= L - 1));
    end
    for (int i = 0; i < 300; i++) step($urandom_range(0, 24) != 0, 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
